// File: rtl/btn_pkg.sv
// Shared types and constants for the button conditioner: channel state,
// channel index map and default timing at the 25 MHz game clock.
package btn_pkg;

    typedef enum logic {
        BTN_RELEASED = 1'b0,
        BTN_PRESSED  = 1'b1
    } btn_state_e;

    // Channel map: player 1 in bits 0-4, player 2 in bits 5-9
    localparam int BTN_P1_UP    = 0;
    localparam int BTN_P1_DOWN  = 1;
    localparam int BTN_P1_LEFT  = 2;
    localparam int BTN_P1_RIGHT = 3;
    localparam int BTN_P1_FIRE  = 4;
    localparam int BTN_P2_UP    = 5;
    localparam int BTN_P2_DOWN  = 6;
    localparam int BTN_P2_LEFT  = 7;
    localparam int BTN_P2_RIGHT = 8;
    localparam int BTN_P2_FIRE  = 9;

    // Default timing: 10 ms debounce, 250 ms first repeat, 100 ms repeat period
    localparam int DEF_N_BTN         = 10;
    localparam int DEF_DEBOUNCE_CYC  = 250000;
    localparam int DEF_REPEAT_DELAY  = 6250000;
    localparam int DEF_REPEAT_PERIOD = 2500000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, symmetric debounce FSM and
// auto-repeat counter. Input is already polarity-corrected (1 = pressed).
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int DW   = $clog2(DEBOUNCE_CYC + 1);
    localparam int RMAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] D_TERM  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [RW-1:0] RD_TERM = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RW-1:0] RP_TERM = RW'(REPEAT_PERIOD - 1);
    localparam bit            REPEAT_EN = (REPEAT_DELAY > 0);

    logic          s1_reg, s_reg;
    btn_state_e    state_reg, state_next;
    logic [DW-1:0] dcnt_reg, dcnt_next;
    logic [RW-1:0] rcnt_reg, rcnt_next;
    logic          phase_reg, phase_next;   // 0 = waiting for first repeat, 1 = period mode
    logic          level_reg, level_next;
    logic          press_reg, press_next;
    logic          release_reg, release_next;
    logic          repeat_reg, repeat_next;

    // Synchronizer and all channel state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg      <= 1'b0;
            s_reg       <= 1'b0;
            state_reg   <= BTN_RELEASED;
            dcnt_reg    <= '0;
            rcnt_reg    <= '0;
            phase_reg   <= 1'b0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            repeat_reg  <= 1'b0;
        end else begin
            s1_reg      <= i_btn;
            s_reg       <= s1_reg;
            state_reg   <= state_next;
            dcnt_reg    <= dcnt_next;
            rcnt_reg    <= rcnt_next;
            phase_reg   <= phase_next;
            level_reg   <= level_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            repeat_reg  <= repeat_next;
        end
    end

    // Debounce FSM and repeat counter; pulses default low every cycle
    always_comb begin
        state_next   = state_reg;
        dcnt_next    = dcnt_reg;
        rcnt_next    = rcnt_reg;
        phase_next   = phase_reg;
        level_next   = level_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        repeat_next  = 1'b0;

        case (state_reg)
            BTN_RELEASED: begin
                if (!s_reg) begin
                    dcnt_next = '0;
                end else if (dcnt_reg == D_TERM) begin
                    state_next  = BTN_PRESSED;
                    level_next  = 1'b1;
                    press_next  = 1'b1;
                    repeat_next = 1'b1;
                    dcnt_next   = '0;
                    rcnt_next   = '0;
                    phase_next  = 1'b0;
                end else begin
                    dcnt_next = dcnt_reg + DW'(1);
                end
            end

            BTN_PRESSED: begin
                // Repeat keeps ticking while the release is being debounced
                if (REPEAT_EN) begin
                    if (!phase_reg && rcnt_reg == RD_TERM) begin
                        repeat_next = 1'b1;
                        rcnt_next   = '0;
                        phase_next  = 1'b1;
                    end else if (phase_reg && rcnt_reg == RP_TERM) begin
                        repeat_next = 1'b1;
                        rcnt_next   = '0;
                    end else begin
                        rcnt_next = rcnt_reg + RW'(1);
                    end
                end

                // Release overrides any repeat tick landing on the same edge
                if (s_reg) begin
                    dcnt_next = '0;
                end else if (dcnt_reg == D_TERM) begin
                    state_next   = BTN_RELEASED;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                    repeat_next  = 1'b0;
                    dcnt_next    = '0;
                    rcnt_next    = '0;
                    phase_next   = 1'b0;
                end else begin
                    dcnt_next = dcnt_reg + DW'(1);
                end
            end

            default: begin
                state_next = BTN_RELEASED;
            end
        endcase
    end

    assign o_level   = level_reg;
    assign o_press   = press_reg;
    assign o_release = release_reg;
    assign o_repeat  = repeat_reg;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw player inputs: polarity correction, then one
// independent debounce/repeat channel per button, plus a press-activity flag.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN         = DEF_N_BTN,
    parameter int ACTIVE_LOW    = 0,
    parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_repeat,
    output logic             o_activity
);

    logic [N_BTN-1:0] pol_btn;

    // Normalise so that 1 always means pressed downstream
    assign pol_btn = i_btn ^ {N_BTN{(ACTIVE_LOW != 0)}};

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi = gi + 1) begin : g_ch
            btn_channel #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC),
                .REPEAT_DELAY (REPEAT_DELAY),
                .REPEAT_PERIOD(REPEAT_PERIOD)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .i_btn    (pol_btn[gi]),
                .o_level  (o_level[gi]),
                .o_press  (o_press[gi]),
                .o_release(o_release[gi]),
                .o_repeat (o_repeat[gi])
            );
        end
    endgenerate

    // Any press pulse on any channel, same cycle as the pulse
    assign o_activity = |o_press;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing
// (debounce 4, repeat delay 10, repeat period 3).
module tb_button_conditioner;

    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn, btn_al;
    logic [N-1:0] lvl, prs, rel, rpt;
    logic [N-1:0] lvl_al, prs_al, rel_al, rpt_al;
    logic         act, act_al;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN(N), .ACTIVE_LOW(0), .DEBOUNCE_CYC(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk), .rst(rst), .i_btn(btn),
        .o_level(lvl), .o_press(prs), .o_release(rel), .o_repeat(rpt), .o_activity(act)
    );

    button_conditioner #(
        .N_BTN(N), .ACTIVE_LOW(1), .DEBOUNCE_CYC(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut_al (
        .clk(clk), .rst(rst), .i_btn(btn_al),
        .o_level(lvl_al), .o_press(prs_al), .o_release(rel_al), .o_repeat(rpt_al),
        .o_activity(act_al)
    );

    // Advance one clock; outputs are sampled at the falling edge
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; btn = '0; btn_al = '1;
        repeat (3) cyc();
        tests++;
        if ({lvl, prs, rel, rpt} !== '0 || act !== 1'b0) begin
            $display("FAIL reset_outputs got lvl=%h prs=%h rel=%h rpt=%h act=%b want all 0", lvl, prs, rel, rpt, act);
            fails++;
        end
        tests++;
        if ({lvl_al, prs_al, rel_al, rpt_al} !== '0 || act_al !== 1'b0) begin
            $display("FAIL reset_outputs_al got lvl=%h prs=%h rel=%h rpt=%h want all 0", lvl_al, prs_al, rel_al, rpt_al);
            fails++;
        end
        $display("[TB] reset: outputs checked");
        rst = 1'b0;
    endtask

    task automatic test_clean_press();
        logic [N-1:0] ep, el, er;
        btn[0] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            ep = (c == 6) ? 10'h001 : 10'h000;
            el = (c >= 6) ? 10'h001 : 10'h000;
            tests++;
            if (prs !== ep || rpt !== ep || act !== (c == 6)) begin
                $display("FAIL clean_press c=%0d got prs=%h rpt=%h act=%b want prs=rpt=%h act=%b", c, prs, rpt, act, ep, (c == 6));
                fails++;
            end
            tests++;
            if (lvl !== el) begin
                $display("FAIL clean_level c=%0d got %h want %h", c, lvl, el);
                fails++;
            end
        end
        $display("[TB] clean_press: press on bit0 checked");
        btn[0] = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            er = (c == 6) ? 10'h001 : 10'h000;
            el = (c >= 6) ? 10'h000 : 10'h001;
            tests++;
            if (rel !== er || lvl !== el || rpt !== '0) begin
                $display("FAIL clean_release c=%0d got rel=%h lvl=%h rpt=%h want rel=%h lvl=%h rpt=0", c, rel, lvl, rpt, er, el);
                fails++;
            end
        end
        $display("[TB] clean_press: release on bit0 checked");
    endtask

    task automatic test_glitch();
        logic [N-1:0] ep;
        btn[4] = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            if (c == 4) btn[4] = 1'b0;
            cyc();
            tests++;
            if (prs !== '0 || lvl !== '0) begin
                $display("FAIL glitch_phase c=%0d got prs=%h lvl=%h want 0", c, prs, lvl);
                fails++;
            end
        end
        btn[4] = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            ep = (c == 6) ? 10'h010 : 10'h000;
            tests++;
            if (prs !== ep || lvl[4] !== (c >= 6)) begin
                $display("FAIL glitch_press c=%0d got prs=%h lvl4=%b want prs=%h lvl4=%b", c, prs, lvl[4], ep, (c >= 6));
                fails++;
            end
        end
        $display("[TB] glitch: rejected glitch, late press on bit4 checked");
        btn[4] = 1'b0;
        repeat (7) cyc();
        tests++;
        if (lvl !== '0) begin
            $display("FAIL glitch_drain got lvl=%h want 0", lvl);
            fails++;
        end
    endtask

    task automatic test_auto_repeat();
        logic [N-1:0] ert, erl, el;
        btn[9] = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            cyc();
            ert = (c == 6 || c == 16 || c == 19 || c == 22 || c == 25) ? 10'h200 : 10'h000;
            erl = (c == 28) ? 10'h200 : 10'h000;
            el  = (c >= 6 && c <= 27) ? 10'h200 : 10'h000;
            tests++;
            if (rpt !== ert) begin
                $display("FAIL repeat c=%0d got rpt=%h want %h", c, rpt, ert);
                fails++;
            end
            tests++;
            if (rel !== erl || lvl !== el) begin
                $display("FAIL repeat_release c=%0d got rel=%h lvl=%h want rel=%h lvl=%h", c, rel, lvl, erl, el);
                fails++;
            end
            if (c == 22) btn[9] = 1'b0;
        end
        $display("[TB] auto_repeat: repeats on bit9 and release checked");
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] ep;
        btn[2] = 1'b1;
        repeat (8) cyc();
        tests++;
        if (lvl !== 10'h004) begin
            $display("FAIL mid_pre_level got %h want 004", lvl);
            fails++;
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        tests++;
        if ({lvl, prs, rel, rpt} !== '0 || act !== 1'b0) begin
            $display("FAIL mid_reset got lvl=%h prs=%h rel=%h rpt=%h want all 0", lvl, prs, rel, rpt);
            fails++;
        end
        for (int c = 1; c <= 7; c++) begin
            cyc();
            ep = (c == 6) ? 10'h004 : 10'h000;
            tests++;
            if (prs !== ep || rel !== '0 || lvl[2] !== (c >= 6)) begin
                $display("FAIL mid_repress c=%0d got prs=%h rel=%h lvl2=%b want prs=%h rel=0 lvl2=%b", c, prs, rel, lvl[2], ep, (c >= 6));
                fails++;
            end
        end
        $display("[TB] reset_mid: abort and fresh press on bit2 checked");
        btn[2] = 1'b0;
        repeat (7) cyc();
    endtask

    task automatic test_active_low();
        logic [N-1:0] ep;
        tests++;
        if (lvl_al !== '0 || prs_al !== '0 || rel_al !== '0) begin
            $display("FAIL al_idle got lvl=%h prs=%h rel=%h want 0", lvl_al, prs_al, rel_al);
            fails++;
        end
        btn_al[7] = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            ep = (c == 6) ? 10'h080 : 10'h000;
            tests++;
            if (prs_al !== ep || act_al !== (c == 6) || lvl_al[7] !== (c >= 6)) begin
                $display("FAIL al_press c=%0d got prs=%h act=%b lvl7=%b want prs=%h act=%b lvl7=%b", c, prs_al, act_al, lvl_al[7], ep, (c == 6), (c >= 6));
                fails++;
            end
        end
        $display("[TB] active_low: press on bit7 checked");
        btn_al[7] = 1'b1;
        repeat (7) cyc();
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] ep;
        btn[1] = 1'b1; btn[6] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            ep = (c == 6) ? 10'h042 : 10'h000;
            tests++;
            if (prs !== ep || act !== (c == 6)) begin
                $display("FAIL simul_press c=%0d got prs=%h act=%b want prs=%h act=%b", c, prs, act, ep, (c == 6));
                fails++;
            end
        end
        btn[1] = 1'b0; btn[6] = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            ep = (c == 6) ? 10'h042 : 10'h000;
            tests++;
            if (rel !== ep) begin
                $display("FAIL simul_release c=%0d got rel=%h want %h", c, rel, ep);
                fails++;
            end
        end
        $display("[TB] simultaneous: bits 1 and 6 checked");
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_auto_repeat();
        test_reset_mid();
        test_active_low();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
